// File: rtl/input_debounce.sv
// Debounces N push-buttons against a slow sample strobe derived from the divided clock.
// Emits registered levels plus one-clk press, release and auto-repeat pulses.
//
//  state | meaning
//  IDLE  | released, waiting for the first high sample
//  PCHK  | counting consecutive high samples toward acceptance
//  HELD  | pressed, counting toward the first repeat
//  RPT   | pressed, repeating every REPEAT_RATE samples
//  RCHK  | still pressed, counting consecutive low samples toward release
module input_debounce #(
  parameter int N_BTN          = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_clk,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_SAMPLES);
  localparam logic [7:0] DELAY_C  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_C   = 8'(REPEAT_RATE);

  typedef enum logic [2:0] {IDLE, PCHK, HELD, RPT, RCHK} state_t;

  logic             s1, s2, s3;
  logic [N_BTN-1:0] raw_s1, raw_s2;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      raw_s1 <= '0;
      raw_s2 <= '0;
    end else begin
      s1     <= sample_clk;
      s2     <= s1;
      s3     <= s2;
      raw_s1 <= btn_raw;
      raw_s2 <= raw_s1;
    end
  end

  // One clk-wide strobe per rising edge of the synchronised slow clock
  assign tick = s2 & ~s3;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, rpt_q, rpt_d;
    logic       level_q, level_d;
    logic       press_q, press_d, rel_q, rel_d, rep_q, rep_d;
    logic [7:0] cnt_inc, rpt_inc;
    logic       raw;

    assign raw     = raw_s2[g];
    assign cnt_inc = cnt_q + 8'd1;
    assign rpt_inc = rpt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rpt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rpt_q   <= rpt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        rep_q   <= rep_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpt_d   = rpt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rep_d   = 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (raw) begin
              cnt_d   = 8'd1;
              state_d = PCHK;
            end
          end
          PCHK: begin
            if (!raw) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else if (cnt_inc == STABLE_C) begin
              cnt_d   = '0;
              rpt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          HELD: begin
            if (!raw) begin
              cnt_d   = 8'd1;
              rpt_d   = '0;
              state_d = RCHK;
            end else if (REPEAT_DELAY != 0) begin
              if (rpt_inc == DELAY_C) begin
                rpt_d   = '0;
                rep_d   = 1'b1;
                state_d = RPT;
              end else begin
                rpt_d = rpt_inc;
              end
            end
          end
          RPT: begin
            if (!raw) begin
              cnt_d   = 8'd1;
              rpt_d   = '0;
              state_d = RCHK;
            end else if (rpt_inc == RATE_C) begin
              rpt_d = '0;
              rep_d = 1'b1;
            end else begin
              rpt_d = rpt_inc;
            end
          end
          RCHK: begin
            if (raw) begin
              // Glitch back to high: restart the repeat delay without a new press
              cnt_d   = '0;
              rpt_d   = '0;
              state_d = HELD;
            end else if (cnt_inc == STABLE_C) begin
              cnt_d   = '0;
              level_d = 1'b0;
              rel_d   = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = rel_q;
    assign btn_repeat[g]  = rep_q;
  end

endmodule
